fpu_issue_ctrl: RTL and testbench

- Sequences the shared multi-cycle FPU: accepts one FP op at a time from decode/execute and drives the FPU's operation select.
- Counts down the op's latency, captures the FPU result and presents it to the writeback port with a destination tag.
- Generates the pipeline stall while the FPU is occupied.
- Sits between the decoder outputs (alu_cont, fpu_stall, rd_reg_src) and the fpu datapath/writeback mux.

---
 rtl/fpu_issue_ctrl.sv | 164 ++++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: issue sequencer for the shared multi-cycle FPU.
// It accepts one FP op at a time, drives the FPU op select and counts the op's
// latency. It captures the FPU result and holds it on the writeback port until
// that port grants it. It also produces the pipeline stall while the FPU is occupied.
//
// Handshake semantics (issue side and writeback side):
//   A transfer happens in a cycle where valid and ready are both high at the
//   rising edge. The offering side keeps its payload stable while valid is high
//   and ready is low. wb_valid never depends on wb_ready. issue_ready may depend
//   on wb_ready, which lets a finished op retire and a new op be accepted in the
//   same cycle.
//
// Optional build: define FPU_ISSUE_PERF_EN to add the saturating perf_ops and
// perf_stall counters. The core behaviour is the same with or without it.
//
// Note: the reset input is named rstn but is active-high (1 = reset asserted).
module fpu_issue_ctrl #(
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 5,
    parameter int LAT_W   = 4,
    parameter int MAX_LAT = 15
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [4:0]        issue_cont,
    input  logic [LAT_W-1:0]  issue_lat,
    input  logic [TAG_W-1:0]  issue_rd,
    input  logic              issue_rd_fp,
    input  logic              flush,
    output logic              opnd_en,
    output logic [4:0]        fpu_cont,
    input  logic [DATA_W-1:0] fpu_y,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [TAG_W-1:0]  wb_rd,
    output logic              wb_rd_fp,
    output logic              busy,
    output logic              stall
`ifdef FPU_ISSUE_PERF_EN
    ,
    output logic [31:0]       perf_ops,
    output logic [31:0]       perf_stall
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [LAT_W-1:0] MAX_LAT_V = LAT_W'(MAX_LAT);

    state_t           state;
    state_t           state_nxt;
    logic [LAT_W-1:0] cnt;
    logic [LAT_W-1:0] lat_clamped;
    logic             accept;
    logic             result_cap;

    // Clamp the requested latency so the counter never loads more than MAX_LAT.
    always_comb begin
        lat_clamped = issue_lat;
        if (issue_lat > MAX_LAT_V) begin
            lat_clamped = MAX_LAT_V;
        end
    end

    // Handshake outputs. While reset is held, every output reads 0.
    always_comb begin
        issue_ready = 1'b0;
        if (!rstn && !flush) begin
            case (state)
                IDLE:    issue_ready = 1'b1;
                DONE:    issue_ready = wb_ready;
                default: issue_ready = 1'b0;
            endcase
        end
        accept     = issue_valid & issue_ready;
        opnd_en    = accept;
        stall      = !rstn & issue_valid & ~issue_ready;
        wb_valid   = (state == DONE);
        busy       = (state != IDLE);
        result_cap = (state == BUSY) && (cnt == '0) && !flush;
    end

    // Next-state logic. Flush has priority over everything else.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = BUSY;
            end
            BUSY: begin
                if (flush)           state_nxt = IDLE;
                else if (cnt == '0)  state_nxt = DONE;
            end
            DONE: begin
                if (flush)           state_nxt = IDLE;
                else if (accept)     state_nxt = BUSY;
                else if (wb_ready)   state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) state <= IDLE;
        else      state <= state_nxt;
    end

    // Latency counter: load on accept, count down in BUSY, never wrap below 0.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= lat_clamped;
        end else if (state == BUSY && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Op select and destination tag change only on accept. This keeps the FPU mux
    // stable through BUSY and DONE.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            fpu_cont <= '0;
            wb_rd    <= '0;
            wb_rd_fp <= 1'b0;
        end else if (accept) begin
            fpu_cont <= issue_cont;
            wb_rd    <= issue_rd;
            wb_rd_fp <= issue_rd_fp;
        end
    end

    // Capture the FPU result in the last BUSY cycle. It stays held through DONE.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn)            wb_data <= '0;
        else if (result_cap) wb_data <= fpu_y;
    end

`ifdef FPU_ISSUE_PERF_EN
    // Saturating event counters for accepted ops and stalled cycles.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else begin
            if (accept && perf_ops != 32'hFFFF_FFFF) begin
                perf_ops <= perf_ops + 32'd1;
            end
            if (stall && perf_stall != 32'hFFFF_FFFF) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed bench for fpu_issue_ctrl.
// A main instance (MAX_LAT=15) is checked every cycle against a cycles-left model.
// A second instance (MAX_LAT=7) covers the latency clamp.
module tb_fpu_issue_ctrl;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 5;
    localparam int LAT_W  = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic              issue_valid, issue_ready, issue_rd_fp, flush, opnd_en;
    logic [4:0]        issue_cont, fpu_cont;
    logic [LAT_W-1:0]  issue_lat;
    logic [TAG_W-1:0]  issue_rd, wb_rd;
    logic [DATA_W-1:0] fpu_y, wb_data;
    logic              wb_valid, wb_ready, wb_rd_fp, busy, stall;

    logic              c_issue_ready, c_opnd_en, c_wb_valid, c_wb_rd_fp, c_busy, c_stall;
    logic [4:0]        c_fpu_cont;
    logic [DATA_W-1:0] c_wb_data;
    logic [TAG_W-1:0]  c_wb_rd;
`ifdef FPU_ISSUE_PERF_EN
    logic [31:0] perf_ops, perf_stall, c_perf_ops, c_perf_stall;
`endif

    fpu_issue_ctrl #(.DATA_W(DATA_W), .TAG_W(TAG_W), .LAT_W(LAT_W), .MAX_LAT(15)) dut (
        .clk(clk), .rstn(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_cont(issue_cont), .issue_lat(issue_lat),
        .issue_rd(issue_rd), .issue_rd_fp(issue_rd_fp),
        .flush(flush), .opnd_en(opnd_en), .fpu_cont(fpu_cont), .fpu_y(fpu_y),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_rd(wb_rd), .wb_rd_fp(wb_rd_fp), .busy(busy), .stall(stall)
`ifdef FPU_ISSUE_PERF_EN
        , .perf_ops(perf_ops), .perf_stall(perf_stall)
`endif
    );

    fpu_issue_ctrl #(.DATA_W(DATA_W), .TAG_W(TAG_W), .LAT_W(LAT_W), .MAX_LAT(7)) dut_c (
        .clk(clk), .rstn(rst),
        .issue_valid(issue_valid), .issue_ready(c_issue_ready),
        .issue_cont(issue_cont), .issue_lat(issue_lat),
        .issue_rd(issue_rd), .issue_rd_fp(issue_rd_fp),
        .flush(flush), .opnd_en(c_opnd_en), .fpu_cont(c_fpu_cont), .fpu_y(fpu_y),
        .wb_valid(c_wb_valid), .wb_ready(wb_ready), .wb_data(c_wb_data),
        .wb_rd(c_wb_rd), .wb_rd_fp(c_wb_rd_fp), .busy(c_busy), .stall(c_stall)
`ifdef FPU_ISSUE_PERF_EN
        , .perf_ops(c_perf_ops), .perf_stall(c_perf_stall)
`endif
    );

    // ---------------- scoreboard counters ----------------
    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // An op is "active" from acceptance until it retires or is cancelled.
    // m_left counts the cycles still to wait before the result is sampled.
    // m_done means a result is waiting for writeback.
    logic              m_active, m_done;
    int                m_left;
    logic [4:0]        m_cont;
    logic [TAG_W-1:0]  m_rd;
    logic              m_rd_fp;
    logic [DATA_W-1:0] m_data;
    int                m_ops, m_stalls;
    logic              e_ready, m_acc;

    assign e_ready = !rst && !flush && (!m_active || (m_done && wb_ready));
    assign m_acc   = issue_valid && e_ready;

    always @(posedge clk) begin
        if (rst) begin
            m_active <= 1'b0; m_done <= 1'b0; m_left <= 0;
            m_cont <= '0; m_rd <= '0; m_rd_fp <= 1'b0; m_data <= '0;
            m_ops <= 0; m_stalls <= 0;
        end else begin
            if (issue_valid && !e_ready) m_stalls <= m_stalls + 1;
            if (m_acc) begin
                m_ops    <= m_ops + 1;
                m_active <= 1'b1;
                m_done   <= 1'b0;
                m_left   <= (int'(issue_lat) > 15) ? 15 : int'(issue_lat);
                m_cont   <= issue_cont;
                m_rd     <= issue_rd;
                m_rd_fp  <= issue_rd_fp;
            end else if (m_active && flush) begin
                m_active <= 1'b0;
                m_done   <= 1'b0;
            end else if (m_active && !m_done) begin
                if (m_left == 0) begin
                    m_data <= fpu_y;
                    m_done <= 1'b1;
                end else begin
                    m_left <= m_left - 1;
                end
            end else if (m_done && wb_ready) begin
                m_active <= 1'b0;
                m_done   <= 1'b0;
            end
        end
    end

    // Compare process: every cycle, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_issue_ready", 32'(issue_ready), 32'd0);
            chk("rst_opnd_en",     32'(opnd_en),     32'd0);
            chk("rst_stall",       32'(stall),       32'd0);
            chk("rst_busy",        32'(busy),        32'd0);
            chk("rst_wb_valid",    32'(wb_valid),    32'd0);
            chk("rst_fpu_cont",    32'(fpu_cont),    32'd0);
            chk("rst_wb_data",     wb_data,          32'd0);
            chk("rst_wb_rd",       32'(wb_rd),       32'd0);
            chk("rst_wb_rd_fp",    32'(wb_rd_fp),    32'd0);
        end else begin
            chk("issue_ready", 32'(issue_ready), 32'(e_ready));
            chk("opnd_en",     32'(opnd_en),     32'(m_acc));
            chk("stall",       32'(stall),       32'(issue_valid && !e_ready));
            chk("busy",        32'(busy),        32'(m_active));
            chk("wb_valid",    32'(wb_valid),    32'(m_done));
            chk("fpu_cont",    32'(fpu_cont),    32'(m_cont));
            if (m_done) begin
                chk("wb_data",  wb_data,        m_data);
                chk("wb_rd",    32'(wb_rd),     32'(m_rd));
                chk("wb_rd_fp", 32'(wb_rd_fp),  32'(m_rd_fp));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic offer(input logic [4:0] cont, input logic [LAT_W-1:0] lat,
                         input logic [TAG_W-1:0] rd, input logic rd_fp);
        issue_valid = 1'b1;
        issue_cont  = cont;
        issue_lat   = lat;
        issue_rd    = rd;
        issue_rd_fp = rd_fp;
    endtask

    // Safety net in case a wait never finishes.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1;
        issue_valid = 1'b0; issue_cont = '0; issue_lat = '0; issue_rd = '0;
        issue_rd_fp = 1'b0; flush = 1'b0; fpu_y = '0; wb_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        settle();
        chk("idle_busy", 32'(busy), 32'd0);

        // fadd, lat 5, accepted in cycle 0; result in cycle 6; writeback from cycle 7.
        step();
        offer(5'b10000, 4'd5, 5'd3, 1'b1);
        wb_ready = 1'b0;
        settle();
        chk("fadd_opnd_en", 32'(opnd_en), 32'd1);
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k <= 7) offer(5'b10001, 4'd2, 5'd8, 1'b0);
            else        issue_valid = 1'b0;
            wb_ready = (k >= 8);
            fpu_y = (k == 6) ? 32'h4040_0000 : $urandom;
            settle();
            if (k <= 7) chk("fadd_stall", 32'(stall), 32'd1);
            if (k <= 7) chk("fadd_opnd_en_low", 32'(opnd_en), 32'd0);
            if (k == 6) chk("fadd_wbv_early", 32'(wb_valid), 32'd0);
            if (k == 7) begin
                chk("fadd_wbv", 32'(wb_valid), 32'd1);
                chk("fadd_data", wb_data, 32'h4040_0000);
                chk("fadd_rd", 32'(wb_rd), 32'd3);
                chk("fadd_rd_fp", 32'(wb_rd_fp), 32'd1);
            end
            if (k == 9) chk("fadd_idle", 32'(busy), 32'd0);
        end

        // fsgnj, lat 0: writeback in cycle 2 only, idle in cycle 3.
        step();
        offer(5'b10110, 4'd0, 5'd5, 1'b1);
        wb_ready = 1'b1;
        settle();
        for (int k = 1; k <= 3; k++) begin
            step();
            issue_valid = 1'b0;
            fpu_y = (k == 1) ? 32'h1234_5678 : $urandom;
            settle();
            chk("fsgnj_wbv", 32'(wb_valid), (k == 2) ? 32'd1 : 32'd0);
            if (k == 2) chk("fsgnj_data", wb_data, 32'h1234_5678);
            if (k == 3) chk("fsgnj_idle", 32'(busy), 32'd0);
        end

        // Back-to-back: fdiv lat 8, then fmul lat 5 held valid.
        step();
        offer(5'b10011, 4'd8, 5'd7, 1'b1);
        wb_ready = 1'b1;
        settle();
        chk("b2b_fdiv_acc", 32'(opnd_en), 32'd1);
        for (int k = 1; k <= 18; k++) begin
            step();
            if (k == 1)  offer(5'b10010, 4'd5, 5'd9, 1'b0);
            if (k == 11) issue_valid = 1'b0;
            fpu_y = (k == 9) ? 32'hAAAA_0001 : ((k == 16) ? 32'hBBBB_0002 : $urandom);
            settle();
            chk("b2b_wbv", 32'(wb_valid), (k == 10 || k == 17) ? 32'd1 : 32'd0);
            chk("b2b_acc", 32'(opnd_en), (k == 10) ? 32'd1 : 32'd0);
            chk("b2b_busy", 32'(busy), (k <= 17) ? 32'd1 : 32'd0);
            if (k == 10) begin
                chk("b2b_fdiv_data", wb_data, 32'hAAAA_0001);
                chk("b2b_fdiv_rd", 32'(wb_rd), 32'd7);
            end
            if (k == 11) chk("b2b_fmul_cont", 32'(fpu_cont), 32'b10010);
            if (k == 17) begin
                chk("b2b_fmul_data", wb_data, 32'hBBBB_0002);
                chk("b2b_fmul_rd", 32'(wb_rd), 32'd9);
            end
        end

        // Writeback backpressure: DONE from cycle 4, wb_ready low until cycle 8.
        step();
        offer(5'b10001, 4'd2, 5'd12, 1'b0);
        wb_ready = 1'b0;
        settle();
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k >= 4 && k <= 7) offer(5'b11000, 4'd1, 5'd20, 1'b1);
            else                  issue_valid = 1'b0;
            wb_ready = (k >= 8);
            fpu_y = (k == 3) ? 32'hCAFE_0003 : $urandom;
            settle();
            if (k >= 4 && k <= 7) begin
                chk("bp_wbv", 32'(wb_valid), 32'd1);
                chk("bp_data", wb_data, 32'hCAFE_0003);
                chk("bp_rd", 32'(wb_rd), 32'd12);
                chk("bp_ready", 32'(issue_ready), 32'd0);
                chk("bp_stall", 32'(stall), 32'd1);
            end
            if (k == 9) chk("bp_idle", 32'(busy), 32'd0);
        end

        // Flush in cycle 3 of a lat 5 op, with a competing issue.
        step();
        offer(5'b10000, 4'd5, 5'd1, 1'b1);
        wb_ready = 1'b1;
        settle();
        for (int k = 1; k <= 10; k++) begin
            step();
            flush = (k == 3 || k == 9);
            if (k == 3) offer(5'b10101, 4'd1, 5'd2, 1'b0);
            if (k == 5 || k == 1) issue_valid = 1'b0;
            fpu_y = $urandom;
            settle();
            if (k <= 4) chk("fl_wbv", 32'(wb_valid), 32'd0);
            if (k == 3) begin
                chk("fl_ready", 32'(issue_ready), 32'd0);
                chk("fl_noacc", 32'(opnd_en), 32'd0);
            end
            if (k == 4) begin
                chk("fl_idle", 32'(busy), 32'd0);
                chk("fl_acc", 32'(opnd_en), 32'd1);
            end
            if (k == 7) chk("fl_new_wbv", 32'(wb_valid), 32'd1);
            if (k >= 9) chk("fl_idle_flush", 32'(busy), 32'd0);
        end
        flush = 1'b0;

        // Reset asserted mid-BUSY: all outputs go to 0 at once, and no writeback follows.
        step();
        offer(5'b11101, 4'd10, 5'd31, 1'b1);
        wb_ready = 1'b0;
        settle();
        for (int k = 1; k <= 3; k++) begin
            step();
            issue_valid = 1'b0;
        end
        offer(5'b10000, 4'd1, 5'd6, 1'b1);
        rst = 1'b1;
        settle();
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_cont", 32'(fpu_cont), 32'd0);
        chk("rstmid_rd", 32'(wb_rd), 32'd0);
        chk("rstmid_rd_fp", 32'(wb_rd_fp), 32'd0);
        chk("rstmid_ready", 32'(issue_ready), 32'd0);
        chk("rstmid_stall", 32'(stall), 32'd0);
        chk("rstmid_opnd", 32'(opnd_en), 32'd0);
        step();
        rst = 1'b0;
        issue_valid = 1'b0;
        wb_ready = 1'b1;
        for (int k = 0; k < 14; k++) begin
            step();
            chk("rstmid_no_wb", 32'(wb_valid), 32'd0);
        end

        // Clamp: lat 15 gives T+9 on the MAX_LAT=7 instance and T+17 on the main one.
        step();
        offer(5'b10000, 4'd15, 5'd4, 1'b0);
        wb_ready = 1'b1;
        settle();
        chk("clamp_acc", 32'(c_opnd_en), 32'd1);
        for (int k = 1; k <= 19; k++) begin
            step();
            issue_valid = 1'b0;
            fpu_y = (k == 8) ? 32'h7777_0007 : ((k == 16) ? 32'hFFFF_000F : $urandom);
            settle();
            chk("clamp7_wbv", 32'(c_wb_valid), (k == 9) ? 32'd1 : 32'd0);
            chk("clamp15_wbv", 32'(wb_valid), (k == 17) ? 32'd1 : 32'd0);
            if (k == 9) begin
                chk("clamp7_data", c_wb_data, 32'h7777_0007);
                chk("clamp7_rd", 32'(c_wb_rd), 32'd4);
            end
            if (k == 17) chk("clamp15_data", wb_data, 32'hFFFF_000F);
        end

        repeat (3) step();
`ifdef FPU_ISSUE_PERF_EN
        chk("perf_ops", perf_ops, 32'(m_ops));
        chk("perf_stall", perf_stall, 32'(m_stalls));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
